load_sequencer: RTL and testbench



---
 rtl/load_sequencer_if.sv | 54 +++++
 rtl/load_sequencer.sv | 143 ++++++++++++++
 tb/tb_load_sequencer.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/load_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : load_sequencer_if
//  Description : Request and memory-read signal bundle for load_sequencer.
//                The master drives load requests and returns read data; the
//                slave (the sequencer) issues reads and returns results.
//  Revision    : 1.0 - initial release
// ============================================================================
interface load_sequencer_if;

   // Load request side
   logic        start;
   logic [31:0] addr;
   logic [1:0]  ct;
   logic        sign_ext;

   // Memory read side
   logic [31:0] mem_addr;
   logic        mem_rd;
   logic [31:0] mem_rdata;

   // Status and result
   logic        busy;
   logic        done;
   logic [31:0] load_data;

   modport master (
      output start,
      output addr,
      output ct,
      output sign_ext,
      output mem_rdata,
      input  mem_addr,
      input  mem_rd,
      input  busy,
      input  done,
      input  load_data
   );

   modport slave (
      input  start,
      input  addr,
      input  ct,
      input  sign_ext,
      input  mem_rdata,
      output mem_addr,
      output mem_rd,
      output busy,
      output done,
      output load_data
   );

endinterface
`default_nettype wire

// File: rtl/load_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : load_sequencer
//  Description : Multicycle load path. Latches a load request, issues one
//                memory read, waits MEM_LATENCY cycles, then extracts the
//                word / halfword / byte from the low lanes of the returned
//                word with optional sign extension and pulses done.
//  Revision    : 1.0 - initial release
// ============================================================================
module load_sequencer #(
   parameter int MEM_LATENCY = 1
) (
   input  wire logic       clk,
   input  wire logic       reset,
   load_sequencer_if.slave bus
);

   // The latency counter is two bits wide, which covers the legal 1..4 range.
   if (MEM_LATENCY < 1 || MEM_LATENCY > 4) begin : g_bad_latency
      $error("load_sequencer: MEM_LATENCY must be in 1..4");
   end

   localparam logic [1:0] LAT_RELOAD = 2'(MEM_LATENCY - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_READ = 2'd1,
      S_WAIT = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic [1:0]  cnt_q, cnt_d;
   logic [1:0]  ct_q, ct_d;
   logic        sign_ext_q, sign_ext_d;
   logic [31:0] mem_addr_q, mem_addr_d;
   logic        mem_rd_q, mem_rd_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic [31:0] load_data_q, load_data_d;

   // Low-lane extraction; ct=11 falls into the word case.
   function automatic logic [31:0] extract(
      input logic [1:0]  size,
      input logic        sx,
      input logic [31:0] word
   );
      logic [31:0] res;
      case (size)
         2'b01:   res = {{16{sx & word[15]}}, word[15:0]};
         2'b10:   res = {{24{sx & word[7]}},  word[7:0]};
         default: res = word;
      endcase
      return res;
   endfunction

   // Next-state and next-output computation; all outputs are registered so
   // each output reflects the state it belongs to in the same cycle.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      ct_d        = ct_q;
      sign_ext_d  = sign_ext_q;
      mem_addr_d  = mem_addr_q;
      mem_rd_d    = 1'b0;
      busy_d      = busy_q;
      done_d      = 1'b0;
      load_data_d = load_data_q;

      case (state_q)
         // DONE accepts like IDLE so back-to-back loads lose no cycle.
         S_IDLE, S_DONE: begin
            if (bus.start) begin
               state_d    = S_READ;
               mem_addr_d = bus.addr;
               ct_d       = bus.ct;
               sign_ext_d = bus.sign_ext;
               mem_rd_d   = 1'b1;
               busy_d     = 1'b1;
            end else begin
               state_d = S_IDLE;
               busy_d  = 1'b0;
            end
         end

         S_READ: begin
            state_d = S_WAIT;
            cnt_d   = LAT_RELOAD;
            busy_d  = 1'b1;
         end

         // Counter reads 0 in the cycle mem_rdata is valid.
         S_WAIT: begin
            if (cnt_q == 2'd0) begin
               state_d     = S_DONE;
               load_data_d = extract(ct_q, sign_ext_q, bus.mem_rdata);
               done_d      = 1'b1;
               busy_d      = 1'b0;
            end else begin
               cnt_d = cnt_q - 2'd1;
            end
         end

         default: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State and output registers; reset overrides any pending request.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         cnt_q       <= 2'd0;
         ct_q        <= 2'd0;
         sign_ext_q  <= 1'b0;
         mem_addr_q  <= 32'd0;
         mem_rd_q    <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         load_data_q <= 32'd0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         ct_q        <= ct_d;
         sign_ext_q  <= sign_ext_d;
         mem_addr_q  <= mem_addr_d;
         mem_rd_q    <= mem_rd_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         load_data_q <= load_data_d;
      end
   end

   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_rd    = mem_rd_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.load_data = load_data_q;

endmodule
`default_nettype wire

// File: tb/tb_load_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_load_sequencer
//  Description : Directed self-checking bench for load_sequencer, with one
//                instance at MEM_LATENCY=1 and one at MEM_LATENCY=3.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_load_sequencer;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   load_sequencer_if ifa ();
   load_sequencer_if ifb ();

   load_sequencer #(.MEM_LATENCY(1)) dut_a (
      .clk   (clk),
      .reset (reset),
      .bus   (ifa.slave)
   );

   load_sequencer #(.MEM_LATENCY(3)) dut_b (
      .clk   (clk),
      .reset (reset),
      .bus   (ifb.slave)
   );

   // Memory model: data is valid only in the cycle MEM_LATENCY after mem_rd,
   // otherwise a poison pattern is returned.
   logic [31:0] resp_a, resp_b;
   logic [0:0]  pipe_a;
   logic [2:0]  pipe_b;

   always @(posedge clk) begin
      if (reset) begin
         pipe_a <= '0;
         pipe_b <= '0;
      end else begin
         pipe_a <= ifa.mem_rd;
         pipe_b <= {pipe_b[1:0], ifb.mem_rd};
      end
   end

   assign ifa.mem_rdata = pipe_a[0] ? resp_a : 32'hBAD0_BAD0;
   assign ifb.mem_rdata = pipe_b[2] ? resp_b : 32'hBAD0_BAD0;

   // Event counters on instance B
   int rd_b = 0;
   int dn_b = 0;
   always @(posedge clk) begin
      if (ifb.mem_rd) rd_b <= rd_b + 1;
      if (ifb.done)   dn_b <= dn_b + 1;
   end

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic wait_done(input bit sel_b, input int limit, output int n);
      n = 0;
      while (!(sel_b ? ifb.done : ifa.done) && n < limit) begin
         tick();
         n++;
      end
   endtask

   // One load on instance A (latency 1). perturb changes request inputs
   // right after accept to show they are ignored.
   task automatic run_a(input string tag, input logic [31:0] addr, input logic [1:0] ct,
                        input logic sx, input logic [31:0] resp, input logic [31:0] exp,
                        input bit perturb);
      int n;
      ifa.addr     = addr;
      ifa.ct       = ct;
      ifa.sign_ext = sx;
      resp_a       = resp;
      ifa.start    = 1'b1;
      tick();
      ifa.start = 1'b0;
      if (perturb) begin
         ifa.ct       = 2'b00;
         ifa.sign_ext = ~sx;
         ifa.addr     = 32'hFFFF_FFFC;
      end
      chk({tag, "_rd"},   {31'd0, ifa.mem_rd}, 32'd1);
      chk({tag, "_addr"}, ifa.mem_addr, addr);
      chk({tag, "_busy"}, {31'd0, ifa.busy}, 32'd1);
      tick();
      chk({tag, "_rd_off"}, {31'd0, ifa.mem_rd}, 32'd0);
      wait_done(1'b0, 6, n);
      chk({tag, "_lat"},  n, 32'd1);
      chk({tag, "_done"}, {31'd0, ifa.done}, 32'd1);
      chk({tag, "_busy_done"}, {31'd0, ifa.busy}, 32'd0);
      chk({tag, "_data"}, ifa.load_data, exp);
      tick();
      chk({tag, "_pulse"}, {31'd0, ifa.done}, 32'd0);
      chk({tag, "_hold"},  ifa.load_data, exp);
   endtask

   initial begin
      int n, snap_rd, snap_dn;
      reset = 1'b1;
      ifa.start = 1'b0; ifa.addr = '0; ifa.ct = '0; ifa.sign_ext = 1'b0;
      ifb.start = 1'b0; ifb.addr = '0; ifb.ct = '0; ifb.sign_ext = 1'b0;
      resp_a = '0;
      resp_b = '0;
      repeat (3) tick();
      reset = 1'b0;

      // Reset values
      chk("rst_addr", ifa.mem_addr, 32'd0);
      chk("rst_rd",   {31'd0, ifa.mem_rd}, 32'd0);
      chk("rst_busy", {31'd0, ifa.busy}, 32'd0);
      chk("rst_done", {31'd0, ifa.done}, 32'd0);
      chk("rst_data", ifa.load_data, 32'd0);
      tick();

      // Extraction patterns at latency 1
      run_a("word",    32'h0000_0040, 2'b00, 1'b0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0);
      run_a("half_sx", 32'h0000_0044, 2'b01, 1'b1, 32'h1234_8001, 32'hFFFF_8001, 1'b0);
      run_a("half_zx", 32'h0000_0048, 2'b01, 1'b0, 32'h1234_8001, 32'h0000_8001, 1'b0);
      run_a("byte_p",  32'h0000_004C, 2'b10, 1'b1, 32'hAABB_CC7F, 32'h0000_007F, 1'b0);
      run_a("byte_n",  32'h0000_0050, 2'b10, 1'b1, 32'hAABB_CC80, 32'hFFFF_FF80, 1'b0);
      run_a("byte_zx", 32'h0000_0054, 2'b10, 1'b0, 32'hAABB_CC80, 32'h0000_0080, 1'b0);
      run_a("ct11",    32'h0000_0058, 2'b11, 1'b1, 32'h1234_8001, 32'h1234_8001, 1'b0);
      run_a("stable",  32'h0000_005C, 2'b10, 1'b1, 32'hAABB_CC80, 32'hFFFF_FF80, 1'b1);

      // Back-to-back with an ignored mid-flight request, latency 3
      snap_rd = rd_b;
      snap_dn = dn_b;
      ifb.addr = 32'h0000_0100; ifb.ct = 2'b00; ifb.sign_ext = 1'b0;
      resp_b = 32'h1111_2222;
      ifb.start = 1'b1;
      tick();                                   // T+1: READ
      ifb.start = 1'b0;
      chk("b2b_rd1", {31'd0, ifb.mem_rd}, 32'd1);
      tick();                                   // T+2: WAIT
      ifb.start = 1'b1;
      ifb.addr  = 32'h0000_0999;
      chk("b2b_busy", {31'd0, ifb.busy}, 32'd1);
      tick();                                   // T+3
      ifb.start = 1'b0;
      chk("b2b_ign_rd", {31'd0, ifb.mem_rd}, 32'd0);
      wait_done(1'b1, 8, n);                    // expect T+5
      chk("b2b_lat1",  n, 32'd2);
      chk("b2b_done1", {31'd0, ifb.done}, 32'd1);
      chk("b2b_data1", ifb.load_data, 32'h1111_2222);
      ifb.addr  = 32'h0000_0200;
      resp_b    = 32'h3333_4444;
      ifb.start = 1'b1;
      tick();                                   // READ of second load
      ifb.start = 1'b0;
      chk("b2b_rd2",   {31'd0, ifb.mem_rd}, 32'd1);
      chk("b2b_addr2", ifb.mem_addr, 32'h0000_0200);
      wait_done(1'b1, 8, n);
      chk("b2b_gap",   n + 1, 32'd5);
      chk("b2b_done2", {31'd0, ifb.done}, 32'd1);
      chk("b2b_data2", ifb.load_data, 32'h3333_4444);
      tick();
      tick();
      chk("b2b_rdcnt", rd_b - snap_rd, 32'd2);
      chk("b2b_dncnt", dn_b - snap_dn, 32'd2);

      // Reset during WAIT
      ifb.addr = 32'h0000_0300;
      resp_b   = 32'h5555_6666;
      ifb.start = 1'b1;
      tick();                                   // READ
      ifb.start = 1'b0;
      tick();                                   // WAIT
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("mid_busy", {31'd0, ifb.busy}, 32'd0);
      chk("mid_data", ifb.load_data, 32'd0);
      chk("mid_addr", ifb.mem_addr, 32'd0);
      chk("mid_done", {31'd0, ifb.done}, 32'd0);
      snap_dn = dn_b;
      repeat (8) tick();
      chk("mid_nodone", dn_b - snap_dn, 32'd0);

      // Reset wins over a simultaneous start
      ifb.addr  = 32'h0000_0400;
      ifb.start = 1'b1;
      reset     = 1'b1;
      tick();
      ifb.start = 1'b0;
      reset     = 1'b0;
      chk("prio_rd",   {31'd0, ifb.mem_rd}, 32'd0);
      chk("prio_busy", {31'd0, ifb.busy}, 32'd0);
      chk("prio_addr", ifb.mem_addr, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
